// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone arbiter for one shared slave: round-robin on contention,
// grant held for the whole cycle, and a watchdog that aborts stalled strobes with err.
`timescale 1ns/1ps

module wb_rr_arbiter #(
   parameter int adr_width = 32,
   parameter int timeout   = 255
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [adr_width-1:0] m0_adr_i,
   input  logic [31:0]          m0_dat_i,
   output logic [31:0]          m0_dat_o,
   input  logic [3:0]           m0_sel_i,
   input  logic                 m0_we_i,
   input  logic                 m0_cyc_i,
   input  logic                 m0_stb_i,
   output logic                 m0_ack_o,
   output logic                 m0_err_o,
   output logic                 m0_rty_o,
   input  logic [adr_width-1:0] m1_adr_i,
   input  logic [31:0]          m1_dat_i,
   output logic [31:0]          m1_dat_o,
   input  logic [3:0]           m1_sel_i,
   input  logic                 m1_we_i,
   input  logic                 m1_cyc_i,
   input  logic                 m1_stb_i,
   output logic                 m1_ack_o,
   output logic                 m1_err_o,
   output logic                 m1_rty_o,
   output logic [adr_width-1:0] s_adr_o,
   output logic [31:0]          s_dat_o,
   input  logic [31:0]          s_dat_i,
   output logic [3:0]           s_sel_o,
   output logic                 s_we_o,
   output logic                 s_cyc_o,
   output logic                 s_stb_o,
   input  logic                 s_ack_i,
   input  logic                 s_err_i,
   input  logic                 s_rty_i,
   output logic [1:0]           gnt_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   state_t state;
   state_t next_state;
   logic   last;
   logic   granted;
   logic   req_cyc;
   logic   req_stb;
   logic   term;
   logic   expire;

   always_comb begin
      granted = (state == GNT0) || (state == GNT1);
      req_cyc = (state == GNT1) ? m1_cyc_i : m0_cyc_i;
      req_stb = (state == GNT1) ? m1_stb_i : m0_stb_i;
      term    = s_ack_i | s_err_i | s_rty_i;
   end

   // Watchdog saturates at the limit by aborting, so the counter never wraps.
   if (timeout > 0) begin : g_wd
      localparam int CW = $clog2(timeout + 1);
      localparam logic [CW-1:0] LIMIT = CW'(timeout - 1);
      logic [CW-1:0] wd_count;

      assign expire = granted && req_stb && !term && (wd_count == LIMIT);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            wd_count <= '0;
         else if (!granted || term || next_state == IDLE)
            wd_count <= '0;
         else if (req_stb)
            wd_count <= wd_count + 1'b1;
      end
   end else begin : g_no_wd
      assign expire = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= next_state;
         if (granted && next_state == IDLE)
            last <= (state == GNT1);
      end
   end

   // Ties go to whichever master was not served last; a grant ends only when cyc drops or the watchdog fires.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i)
               next_state = last ? GNT0 : GNT1;
            else if (m0_cyc_i)
               next_state = GNT0;
            else if (m1_cyc_i)
               next_state = GNT1;
         end
         GNT0, GNT1: begin
            if (expire || !req_cyc)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      gnt_o    = 2'b00;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_rty_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_rty_o = 1'b0;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      case (state)
         GNT0: begin
            gnt_o    = 2'b01;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i & ~expire;
            s_stb_o  = m0_stb_i & ~expire;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | expire;
            m0_rty_o = s_rty_i;
         end
         GNT1: begin
            gnt_o    = 2'b10;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i & ~expire;
            s_stb_o  = m1_stb_i & ~expire;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | expire;
            m1_rty_o = s_rty_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a transaction-level model of owner/turn/stall
// is checked against the DUT every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps

module tb_wb_rr_arbiter;

   localparam int TIMEOUT = 8;

   logic        clk;
   logic        reset_n;
   logic [31:0] adr_in [2];
   logic [31:0] dat_in [2];
   logic [3:0]  sel_in [2];
   logic        we_in  [2];
   logic        cyc_in [2];
   logic        stb_in [2];
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m0_err_o, m0_rty_o;
   logic        m1_ack_o, m1_err_o, m1_rty_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o;
   logic        s_ack_i, s_err_i, s_rty_i;
   logic [1:0]  gnt_o;

   int total = 0;
   int bad   = 0;

   int owner       = -1;
   int last_served = 1;
   int stall       = 0;

   wb_rr_arbiter #(.adr_width(32), .timeout(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_adr_i(adr_in[0]), .m0_dat_i(dat_in[0]), .m0_dat_o(m0_dat_o), .m0_sel_i(sel_in[0]),
      .m0_we_i(we_in[0]), .m0_cyc_i(cyc_in[0]), .m0_stb_i(stb_in[0]),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
      .m1_adr_i(adr_in[1]), .m1_dat_i(dat_in[1]), .m1_dat_o(m1_dat_o), .m1_sel_i(sel_in[1]),
      .m1_we_i(we_in[1]), .m1_cyc_i(cyc_in[1]), .m1_stb_i(stb_in[1]),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
      .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .gnt_o(gnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The granted master has stalled a full timeout window with no slave response.
   function automatic bit timed_out();
      if (owner < 0 || TIMEOUT == 0) return 1'b0;
      return stb_in[owner] && !(s_ack_i || s_err_i || s_rty_i) && (stall == TIMEOUT - 1);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner       <= -1;
         last_served <= 1;
         stall       <= 0;
      end else if (owner < 0) begin
         if (cyc_in[0] && cyc_in[1])
            owner <= 1 - last_served;
         else if (cyc_in[0])
            owner <= 0;
         else if (cyc_in[1])
            owner <= 1;
      end else if (timed_out() || !cyc_in[owner]) begin
         last_served <= owner;
         owner       <= -1;
         stall       <= 0;
      end else if (s_ack_i || s_err_i || s_rty_i)
         stall <= 0;
      else if (stb_in[owner])
         stall <= stall + 1;
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      logic [1:0]  e_gnt;
      logic [6:0]  e_ctl;
      logic [31:0] e_adr, e_dat;
      logic [2:0]  e_t0, e_t1;
      bit          ab;
      ab    = timed_out();
      e_gnt = 2'b00;
      e_ctl = '0;
      e_adr = '0;
      e_dat = '0;
      if (owner >= 0) begin
         e_gnt = (owner == 0) ? 2'b01 : 2'b10;
         e_ctl = {cyc_in[owner] && !ab, stb_in[owner] && !ab, we_in[owner], sel_in[owner]};
         e_adr = adr_in[owner];
         e_dat = dat_in[owner];
      end
      e_t0 = {owner == 0 && s_ack_i, owner == 0 && (s_err_i || ab), owner == 0 && s_rty_i};
      e_t1 = {owner == 1 && s_ack_i, owner == 1 && (s_err_i || ab), owner == 1 && s_rty_i};
      check_output("gnt", 64'(gnt_o), 64'(e_gnt));
      check_output("s_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'(e_ctl));
      check_output("s_adr", 64'(s_adr_o), 64'(e_adr));
      check_output("s_dat", 64'(s_dat_o), 64'(e_dat));
      check_output("m0_term", 64'({m0_ack_o, m0_err_o, m0_rty_o}), 64'(e_t0));
      check_output("m1_term", 64'({m1_ack_o, m1_err_o, m1_rty_o}), 64'(e_t1));
      check_output("m_dat", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
   endtask

   always @(negedge clk) compare_model();

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic apply_stimulus(input int m, input logic c, input logic s, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
      cyc_in[m] = c;
      stb_in[m] = s;
      we_in[m]  = w;
      adr_in[m] = a;
      dat_in[m] = d;
      sel_in[m] = c ? 4'hF : 4'h0;
   endtask

   task automatic set_slave(input logic ack, input logic err, input logic rty, input logic [31:0] d);
      s_ack_i = ack;
      s_err_i = err;
      s_rty_i = rty;
      s_dat_i = d;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      apply_stimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      apply_stimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_slave(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) cycle();
      settle();
      check_output("rst_gnt", 64'(gnt_o), 64'(2'b00));
      check_output("rst_scyc", 64'({s_cyc_o, s_stb_o}), 64'(2'b00));
      cycle();
      reset_n = 1'b1;

      // Single m0 read with m1 idle.
      cycle(); apply_stimulus(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0); settle();
      check_output("t1_idle_gnt", 64'(gnt_o), 64'(2'b00));
      cycle(); settle();
      check_output("t1_gnt", 64'(gnt_o), 64'(2'b01));
      check_output("t1_scyc", 64'(s_cyc_o), 64'(1'b1));
      check_output("t1_sadr", 64'(s_adr_o), 64'(32'h100));
      cycle(); set_slave(1'b1, 1'b0, 1'b0, 32'hDEADBEEF); settle();
      check_output("t1_m0ack", 64'(m0_ack_o), 64'(1'b1));
      check_output("t1_m0dat", 64'(m0_dat_o), 64'(32'hDEADBEEF));
      check_output("t1_m1ack", 64'(m1_ack_o), 64'(1'b0));
      cycle(); apply_stimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_slave(1'b0, 1'b0, 1'b0, 32'h0);
      cycle(); settle();
      check_output("t1_release", 64'(gnt_o), 64'(2'b00));

      // Fresh reset, simultaneous requests: m0 first, one idle cycle, then m1.
      cycle(); reset_n = 1'b0;
      cycle(); reset_n = 1'b1;
      cycle();
      apply_stimulus(0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
      apply_stimulus(1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h1234);
      cycle(); set_slave(1'b1, 1'b0, 1'b0, 32'hA5A50001); settle();
      check_output("t2_first", 64'(gnt_o), 64'(2'b01));
      check_output("t2_m1noack", 64'(m1_ack_o), 64'(1'b0));
      cycle(); apply_stimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_slave(1'b0, 1'b0, 1'b0, 32'h0);
      cycle(); settle();
      check_output("t2_gap", 64'(gnt_o), 64'(2'b00));
      cycle(); set_slave(1'b0, 1'b1, 1'b0, 32'h0); settle();
      check_output("t2_second", 64'(gnt_o), 64'(2'b10));
      check_output("t2_sdat", 64'(s_dat_o), 64'(32'h1234));
      check_output("t2_m1err", 64'({m1_err_o, m0_err_o}), 64'(2'b10));
      cycle(); set_slave(1'b0, 1'b0, 1'b1, 32'h0); settle();
      check_output("t2_m1rty", 64'({m1_rty_o, m0_rty_o}), 64'(2'b10));
      cycle(); set_slave(1'b1, 1'b0, 1'b0, 32'hCAFE0002); settle();
      check_output("t2_m1ack", 64'({m1_ack_o, m0_ack_o}), 64'(2'b10));
      check_output("t2_m1dat", 64'(m1_dat_o), 64'(32'hCAFE0002));
      cycle(); apply_stimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_slave(1'b0, 1'b0, 1'b0, 32'h0);
      cycle();

      // m0 burst of four acked beats is not preempted by m1.
      cycle();
      apply_stimulus(0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
      apply_stimulus(1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         set_slave(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i));
         apply_stimulus(0, 1'b1, 1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'h0);
         settle();
         check_output("t3_burst_gnt", 64'(gnt_o), 64'(2'b01));
         check_output("t3_burst_ack", 64'({m1_ack_o, m0_ack_o}), 64'(2'b01));
      end
      cycle(); apply_stimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_slave(1'b0, 1'b0, 1'b0, 32'h0); settle();
      check_output("t3_tail", 64'(gnt_o), 64'(2'b01));
      cycle(); settle();
      check_output("t3_gap", 64'(gnt_o), 64'(2'b00));
      cycle(); set_slave(1'b1, 1'b0, 1'b0, 32'h55); settle();
      check_output("t3_m1", 64'(gnt_o), 64'(2'b10));
      cycle(); apply_stimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_slave(1'b0, 1'b0, 1'b0, 32'h0);
      cycle();

      // Continuous contention alternates strictly, starting with m0 (m1 served last).
      cycle();
      apply_stimulus(0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0);
      apply_stimulus(1, 1'b1, 1'b1, 1'b0, 32'h700, 32'h0);
      for (int r = 0; r < 4; r++) begin
         int n;
         logic [1:0] g;
         n = r % 2;
         g = (n == 0) ? 2'b01 : 2'b10;
         cycle(); set_slave(1'b1, 1'b0, 1'b0, 32'(r)); settle();
         check_output("t4_grant", 64'(gnt_o), 64'(g));
         cycle(); apply_stimulus(n, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_slave(1'b0, 1'b0, 1'b0, 32'h0); settle();
         check_output("t4_hold", 64'(gnt_o), 64'(g));
         cycle();
         if (r < 3) apply_stimulus(n, 1'b1, 1'b1, 1'b0, 32'h600 + 32'(n * 256), 32'h0);
         settle();
         check_output("t4_gap", 64'(gnt_o), 64'(2'b00));
      end
      cycle(); apply_stimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle();
      cycle();

      // Watchdog: unanswered m1 write aborts on the 8th strobe cycle.
      cycle(); apply_stimulus(1, 1'b1, 1'b1, 1'b1, 32'h800, 32'hBEEF);
      for (int k = 1; k <= 8; k++) begin
         cycle(); settle();
         check_output("t5_err", 64'(m1_err_o), 64'(k == 8));
         check_output("t5_scyc", 64'({s_cyc_o, s_stb_o}), 64'((k == 8) ? 2'b00 : 2'b11));
      end
      cycle(); apply_stimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
      check_output("t5_after", 64'(gnt_o), 64'(2'b00));
      cycle();

      // Ack on the 8th cycle beats the watchdog.
      cycle(); apply_stimulus(1, 1'b1, 1'b1, 1'b1, 32'h900, 32'hF00D);
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (k == 8) set_slave(1'b1, 1'b0, 1'b0, 32'h0);
         settle();
         check_output("t5b_err", 64'(m1_err_o), 64'(1'b0));
      end
      check_output("t5b_ack", 64'({m1_ack_o, s_cyc_o}), 64'(2'b11));
      cycle(); apply_stimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_slave(1'b0, 1'b0, 1'b0, 32'h0); settle();
      check_output("t5b_hold", 64'(gnt_o), 64'(2'b10));
      cycle(); settle();
      check_output("t5b_idle", 64'(gnt_o), 64'(2'b00));

      // Asynchronous reset in the middle of an m1 grant.
      cycle(); apply_stimulus(1, 1'b1, 1'b1, 1'b0, 32'hA00, 32'h0);
      cycle(); #2;
      check_output("t6_pre", 64'(gnt_o), 64'(2'b10));
      apply_stimulus(0, 1'b1, 1'b1, 1'b0, 32'hB00, 32'h0);
      reset_n = 1'b0;
      #1;
      check_output("t6_async", 64'({gnt_o, s_cyc_o}), 64'(3'b000));
      cycle();
      cycle(); reset_n = 1'b1;
      cycle(); settle();
      check_output("t6_m0_first", 64'(gnt_o), 64'(2'b01));
      cycle(); set_slave(1'b1, 1'b0, 1'b0, 32'h77); settle();
      check_output("t6_m0ack", 64'({m1_ack_o, m0_ack_o}), 64'(2'b01));
      cycle(); apply_stimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_slave(1'b0, 1'b0, 1'b0, 32'h0);
      cycle();
      cycle(); settle();
      check_output("t6_m1_next", 64'(gnt_o), 64'(2'b10));
      cycle(); apply_stimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
